// File: rtl/bus_memory_responder.sv
// Bus target backed by a word-addressed SRAM: decodes a window at BASE_ADDRESS,
// accepts byte-masked write bursts and streams read bursts with busy back-pressure.
module bus_memory_responder #(
    parameter logic [31:0] BASE_ADDRESS = 32'h5000_0000,
    parameter int          SIZE_LOG2    = 10
) (
    input  logic        clock,
    input  logic        n_reset,
    input  logic [31:0] address_dataIN,
    input  logic [3:0]  byte_enableIN,
    input  logic [7:0]  burst_sizeIN,
    input  logic        read_n_writeIN,
    input  logic        begin_transactionIN,
    input  logic        end_transactionIN,
    input  logic        data_validIN,
    input  logic        busyIN,
    output logic [31:0] address_dataOUT,
    output logic        end_transactionOUT,
    output logic        data_validOUT,
    output logic        busyOUT,
    output logic        errorOUT
);
    localparam int AW    = SIZE_LOG2;
    localparam int DEPTH = 1 << SIZE_LOG2;

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_WRITE      = 3'd1;
    localparam logic [2:0] S_READ_FETCH = 3'd2;
    localparam logic [2:0] S_READ       = 3'd3;
    localparam logic [2:0] S_READ_END   = 3'd4;
    localparam logic [2:0] S_ERR        = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [7:0]    rem_q, rem_d;
    logic [3:0]    be_q, be_d;
    logic          done_q, done_d;

    logic [31:0]   mem [DEPTH];
    logic [31:0]   rdata_q;

    logic          sel, bad;
    logic [AW-1:0] begin_idx, idx_inc, rd_addr;
    logic [31:0]   span;
    logic          wr_en, rd_en;

    assign sel       = address_dataIN[31:AW+2] == BASE_ADDRESS[31:AW+2];
    assign begin_idx = address_dataIN[AW+1:2];
    assign span      = 32'(begin_idx) + 32'(burst_sizeIN);
    assign bad       = (address_dataIN[1:0] != 2'b00) || (span > 32'(DEPTH - 1));
    assign idx_inc   = idx_q + AW'(1);
    // done_q marks a write burst whose last beat has landed; later beats are dropped.
    assign wr_en     = (state_q == S_WRITE) && data_validIN && !done_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        be_d    = be_q;
        done_d  = done_q;
        rd_en   = 1'b0;
        rd_addr = idx_q;
        case (state_q)
            S_IDLE: begin
                if (begin_transactionIN && sel) begin
                    if (bad) begin
                        state_d = S_ERR;
                    end else begin
                        idx_d   = begin_idx;
                        rem_d   = burst_sizeIN;
                        be_d    = byte_enableIN;
                        done_d  = 1'b0;
                        state_d = read_n_writeIN ? S_READ_FETCH : S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (wr_en) begin
                    if (rem_q == 8'd0) begin
                        done_d = 1'b1;
                    end else begin
                        idx_d = idx_inc;
                        rem_d = rem_q - 8'd1;
                    end
                end
                if (end_transactionIN) state_d = S_IDLE;
            end
            S_READ_FETCH: begin
                rd_en   = 1'b1;
                state_d = end_transactionIN ? S_IDLE : S_READ;
            end
            S_READ: begin
                // Prefetch the next word while the current one is consumed: no bubble.
                if (end_transactionIN) begin
                    state_d = S_IDLE;
                end else if (!busyIN) begin
                    if (rem_q == 8'd0) begin
                        state_d = S_READ_END;
                    end else begin
                        idx_d   = idx_inc;
                        rem_d   = rem_q - 8'd1;
                        rd_en   = 1'b1;
                        rd_addr = idx_inc;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            rem_q   <= '0;
            be_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            be_q    <= be_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) mem[idx_q][8*b +: 8] <= address_dataIN[8*b +: 8];
            end
        end
        if (rd_en) rdata_q <= mem[rd_addr];
    end

    // Outputs decode straight from state so they drop with the async reset.
    assign data_validOUT      = (state_q == S_READ);
    assign address_dataOUT    = data_validOUT ? rdata_q : 32'd0;
    assign end_transactionOUT = (state_q == S_READ_END) || (state_q == S_ERR);
    assign errorOUT           = (state_q == S_ERR);
    assign busyOUT            = 1'b0;
endmodule

// File: tb/tb_bus_memory_responder.sv
// Directed bench for bus_memory_responder: writes, masked writes, stalled reads,
// window/alignment errors, unselected addresses and mid-burst reset.
module tb_bus_memory_responder;
    logic        clock = 1'b0;
    logic        n_reset;
    logic [31:0] address_dataIN;
    logic [3:0]  byte_enableIN;
    logic [7:0]  burst_sizeIN;
    logic        read_n_writeIN;
    logic        begin_transactionIN;
    logic        end_transactionIN;
    logic        data_validIN;
    logic        busyIN;
    logic [31:0] address_dataOUT;
    logic        end_transactionOUT;
    logic        data_validOUT;
    logic        busyOUT;
    logic        errorOUT;

    int checks   = 0;
    int failures = 0;

    logic [31:0] wbuf [8];
    logic [31:0] rbuf [8];
    int          stall [8];

    // flag encoding: error=8, end=4, data_valid=2, busy=1
    localparam logic [31:0] F_NONE = 32'd0;
    localparam logic [31:0] F_DV   = 32'd2;
    localparam logic [31:0] F_END  = 32'd4;
    localparam logic [31:0] F_ERR  = 32'd12;

    bus_memory_responder dut (
        .clock(clock), .n_reset(n_reset),
        .address_dataIN(address_dataIN), .byte_enableIN(byte_enableIN),
        .burst_sizeIN(burst_sizeIN), .read_n_writeIN(read_n_writeIN),
        .begin_transactionIN(begin_transactionIN), .end_transactionIN(end_transactionIN),
        .data_validIN(data_validIN), .busyIN(busyIN),
        .address_dataOUT(address_dataOUT), .end_transactionOUT(end_transactionOUT),
        .data_validOUT(data_validOUT), .busyOUT(busyOUT), .errorOUT(errorOUT)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] flags();
        return {28'd0, errorOUT, end_transactionOUT, data_validOUT, busyOUT};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_in();
        address_dataIN      = '0;
        byte_enableIN       = '0;
        burst_sizeIN        = '0;
        read_n_writeIN      = 1'b0;
        begin_transactionIN = 1'b0;
        end_transactionIN   = 1'b0;
        data_validIN        = 1'b0;
        busyIN              = 1'b0;
    endtask

    task automatic do_begin(input logic [31:0] addr, input logic [3:0] be,
                            input logic [7:0] burst, input logic rnw);
        address_dataIN      = addr;
        byte_enableIN       = be;
        burst_sizeIN        = burst;
        read_n_writeIN      = rnw;
        begin_transactionIN = 1'b1;
        step();
        idle_in();
    endtask

    // n beats from wbuf, end_transactionIN on the last one
    task automatic do_write(input logic [31:0] addr, input logic [3:0] be,
                            input logic [7:0] burst, input int n);
        do_begin(addr, be, burst, 1'b0);
        for (int i = 0; i < n; i++) begin
            data_validIN      = 1'b1;
            address_dataIN    = wbuf[i];
            end_transactionIN = (i == n - 1);
            chk("wr_flags", flags(), F_NONE);
            step();
        end
        idle_in();
        step();
    endtask

    // expects rbuf[0..burst], stalls stall[i] cycles on beat i
    task automatic do_read(input string tag, input logic [31:0] addr, input logic [7:0] burst);
        do_begin(addr, 4'h0, burst, 1'b1);
        chk({tag, "_fetch_flags"}, flags(), F_NONE);
        chk({tag, "_fetch_data"}, address_dataOUT, 32'd0);
        step();
        for (int i = 0; i <= int'(burst); i++) begin
            for (int s = 0; s < stall[i]; s++) begin
                busyIN = 1'b1;
                chk({tag, "_stall_flags"}, flags(), F_DV);
                chk({tag, "_stall_data"}, address_dataOUT, rbuf[i]);
                step();
            end
            busyIN = 1'b0;
            chk({tag, "_beat_flags"}, flags(), F_DV);
            chk({tag, "_beat_data"}, address_dataOUT, rbuf[i]);
            step();
        end
        chk({tag, "_end_flags"}, flags(), F_END);
        chk({tag, "_end_data"}, address_dataOUT, 32'd0);
        step();
        chk({tag, "_after_flags"}, flags(), F_NONE);
        for (int i = 0; i < 8; i++) stall[i] = 0;
    endtask

    // rejected begin; a stray write beat in the error cycle must be dropped
    task automatic err_begin(input string tag, input logic [31:0] addr,
                             input logic [7:0] burst, input logic rnw);
        do_begin(addr, 4'hF, burst, rnw);
        data_validIN   = 1'b1;
        address_dataIN = 32'hBAD0_BAD0;
        chk({tag, "_err_flags"}, flags(), F_ERR);
        step();
        idle_in();
        chk({tag, "_err_after"}, flags(), F_NONE);
        step();
    endtask

    initial begin
        for (int i = 0; i < 8; i++) stall[i] = 0;
        idle_in();
        n_reset = 1'b0;
        #2;
        chk("reset_flags", flags(), F_NONE);
        chk("reset_data", address_dataOUT, 32'd0);
        repeat (2) @(posedge clock);
        #1 n_reset = 1'b1;
        step();

        // single-beat write then read back
        wbuf[0] = 32'hDEAD_BEEF;
        do_write(32'h5000_0010, 4'hF, 8'd0, 1);
        rbuf[0] = 32'hDEAD_BEEF;
        do_read("rd1", 32'h5000_0010, 8'd0);

        // 4-beat write, masked overwrite of word 1, 4-beat read
        wbuf[0] = 32'd1; wbuf[1] = 32'd2; wbuf[2] = 32'd3; wbuf[3] = 32'd4;
        do_write(32'h5000_0100, 4'hF, 8'd3, 4);
        wbuf[0] = 32'hFFFF_FFFF;
        do_write(32'h5000_0104, 4'b0101, 8'd0, 1);
        rbuf[0] = 32'd1; rbuf[1] = 32'h00FF_00FF; rbuf[2] = 32'd3; rbuf[3] = 32'd4;
        do_read("rd4", 32'h5000_0100, 8'd3);

        // busy stalls on the first two beats
        stall[0] = 2; stall[1] = 2;
        do_read("rdstall", 32'h5000_0100, 8'd2);

        // beats past the burst length are discarded
        wbuf[0] = 32'h11;
        do_write(32'h5000_0204, 4'hF, 8'd0, 1);
        wbuf[0] = 32'h22; wbuf[1] = 32'h33;
        do_write(32'h5000_0200, 4'hF, 8'd0, 2);
        rbuf[0] = 32'h22; rbuf[1] = 32'h11;
        do_read("rddisc", 32'h5000_0200, 8'd1);

        // misaligned begin
        wbuf[0] = 32'hCAFE_0000;
        do_write(32'h5000_0000, 4'hF, 8'd0, 1);
        err_begin("misal", 32'h5000_0002, 8'd0, 1'b0);
        rbuf[0] = 32'hCAFE_0000;
        do_read("rdmisal", 32'h5000_0000, 8'd0);

        // burst leaving the window, then the legal last-word burst
        wbuf[0] = 32'h1234_5678;
        do_write(32'h5000_0FFC, 4'hF, 8'd0, 1);
        err_begin("ovf_w", 32'h5000_0FFC, 8'd1, 1'b0);
        err_begin("ovf_r", 32'h5000_0FFC, 8'd1, 1'b1);
        rbuf[0] = 32'h1234_5678;
        do_read("rdovf", 32'h5000_0FFC, 8'd0);
        wbuf[0] = 32'h8765_4321;
        do_write(32'h5000_0FFC, 4'hF, 8'd0, 1);
        rbuf[0] = 32'h8765_4321;
        do_read("rdlast", 32'h5000_0FFC, 8'd0);

        // unselected address: read and write produce nothing
        do_begin(32'h6000_0000, 4'hF, 8'd0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("nosel_rd_flags", flags(), F_NONE);
            chk("nosel_rd_data", address_dataOUT, 32'd0);
            step();
        end
        wbuf[0] = 32'h9999_9999; wbuf[1] = 32'h8888_8888;
        do_write(32'h6000_0000, 4'hF, 8'd1, 2);
        rbuf[0] = 32'hCAFE_0000;
        do_read("rdnosel", 32'h5000_0000, 8'd0);

        // async reset during beat 2 of a 4-beat read
        do_begin(32'h5000_0100, 4'h0, 8'd3, 1'b1);
        step();
        chk("rst_beat1", address_dataOUT, 32'd1);
        step();
        chk("rst_beat2", address_dataOUT, 32'h00FF_00FF);
        #1 n_reset = 1'b0;
        #1;
        chk("rst_async_flags", flags(), F_NONE);
        chk("rst_async_data", address_dataOUT, 32'd0);
        step();
        n_reset = 1'b1;
        step();
        chk("rst_idle_flags", flags(), F_NONE);
        rbuf[0] = 32'd1; rbuf[1] = 32'h00FF_00FF; rbuf[2] = 32'd3; rbuf[3] = 32'd4;
        do_read("rdpost", 32'h5000_0100, 8'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bus_memory_responder.md
Name: bus_memory_responder

Overview:
- Bus target (responder) for the shared transaction bus that the DMA initiator drives: decodes begin_transaction, accepts write bursts and serves read bursts from a local word-addressed SRAM.
- Sits on the same bus segment as the JTAG DMA. Used as a scratch memory and as the DMA's loop-back verification target.
- All outputs are OR-combined on the bus, so every output is 0 whenever the block is not actively responding.

Parameters:
BASE_ADDRESS, 32'h5000_0000, byte address of word 0; must be aligned to the window size
SIZE_LOG2, 10, log2 of the memory depth in 32-bit words (window = 4<<SIZE_LOG2 bytes)

Ports:
clock  input  1  system clock; all logic on rising edge
n_reset  input  1  asynchronous, active-low reset
address_dataIN  input  32  address in the begin cycle; write data in data beats
byte_enableIN  input  4  write byte lanes, sampled in the begin cycle, applied to every write beat
burst_sizeIN  input  8  beats minus one, sampled in the begin cycle
read_n_writeIN  input  1  1 = read, 0 = write, sampled in the begin cycle
begin_transactionIN  input  1  one-cycle transaction start
end_transactionIN  input  1  initiator ends or aborts the transaction
data_validIN  input  1  write beat present on address_dataIN
busyIN  input  1  initiator stalls read beats
address_dataOUT  output  32  read data; 0 when data_validOUT=0
end_transactionOUT  output  1  responder completes a read or error transaction
data_validOUT  output  1  read beat present
busyOUT  output  1  responder stall; tied 0 (no stalls generated)
errorOUT  output  1  transaction rejected

Behaviour:
- Reset: all outputs 0; state IDLE; burst counter and address register 0. Memory contents are not reset.
- Asserting n_reset mid-transaction forces IDLE immediately; outputs go 0 asynchronously.
- Decode, in IDLE only, on begin_transactionIN:
  - Selected when address[31:SIZE_LOG2+2] == BASE_ADDRESS[31:SIZE_LOG2+2]. If not selected, stay IDLE and drive nothing.
  - Selected but address[1:0] != 0, or word_index + burst_sizeIN > 2^SIZE_LOG2 - 1 (burst would leave the window): go to ERR.
  - Otherwise latch word_index = address[SIZE_LOG2+1:2], remaining = burst_sizeIN, byte enables and direction; go to READ_FETCH (read) or WRITE (write).
- begin_transactionIN is ignored in every state other than IDLE.
- WRITE:
  - Each cycle with data_validIN=1, write address_dataIN into mem[word_index], enabled byte lanes only.
  - Per beat: word_index += 1; remaining -= 1.
  - Beats arriving after remaining has reached 0 are discarded.
  - end_transactionIN=1 returns to IDLE the next cycle. A beat in that same cycle with data_validIN=1 is still written.
  - The responder never asserts end_transactionOUT for writes.
- READ_FETCH: one cycle. Synchronous RAM read of mem[word_index]. Outputs stay 0.
  - The first data beat therefore appears 2 cycles after the begin cycle.
- READ:
  - data_validOUT=1, address_dataOUT = current word; byte enables are ignored (full word returned).
  - If busyIN=1, hold the same data and data_valid; nothing advances.
  - If busyIN=0, the beat is consumed. If remaining==0 go to READ_END; else word_index += 1, remaining -= 1, and the next word appears on the following cycle with no bubble (RAM read address = next index when not stalled).
  - end_transactionIN=1 in any READ or READ_FETCH cycle aborts: IDLE next cycle, outputs 0.
- READ_END: end_transactionOUT=1 for exactly one cycle, data_validOUT=0, then IDLE.
- ERR: errorOUT=1 and end_transactionOUT=1 for exactly one cycle, then IDLE. Any write beats the initiator sends afterwards are ignored.
- A burst ending exactly on the last word of the window is legal.
- Word index arithmetic is SIZE_LOG2 bits wide; the range check guarantees no wrap-around inside a burst.
- Transaction cost in cycles: a read of N beats with no stalls = 1 (begin) + 1 (fetch) + N + 1 (end). A write = beats as delivered by the initiator.

Test Plan:
- Write 1 beat 0xDEADBEEF at 0x5000_0010, be=4'hF; then read burst 0 from the same address -> data_validOUT on cycle begin+2 with 0xDEADBEEF; end_transactionOUT on begin+3; errorOUT never set.
- Write burst 3 (4 beats, values 1..4) at 0x5000_0100; write 0xFFFF_FFFF at 0x5000_0104 with be=4'b0101; read burst 3 -> 1, 0x00FF_00FF, 3, 4 on four consecutive cycles.
- Read burst 2 with busyIN high on beats 1 and 2 for 2 cycles each -> each word held unchanged while stalled; 3 beats delivered in order; single end_transactionOUT pulse.
- Begin at 0x5000_0002, and separately at the last word 0x5000_0FFC with burst 1 -> errorOUT and end_transactionOUT high together for one cycle; memory unchanged. The same last word with burst 0 -> succeeds.
- Begin at 0x6000_0000 (read and write) -> all outputs remain 0; memory unchanged.
- Assert n_reset low during beat 2 of a 4-beat read -> outputs 0 immediately. After release, a new read of previously written data returns the correct values.
